alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the combinational execute-stage ALU. Accepts one operation per transaction over a valid/ready input channel, produces a registered result on a valid/ready output channel. Adds signed/unsigned compare, and an iterative unsigned multiply/divide unit that can be compiled out. Sits between the decode/issue stage and writeback; back-pressure from writeback stalls it cleanly.

## Interface
- `WIDTH`, 32, operand/result width; power of two, 8..64.
- `SHW`, `$clog2(WIDTH)`, shift-amount width, derived; do not override.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept an operation.
- `op`  in  4  opcode, encoding below.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  WIDTH  result.
- `zero`  out  1  `result == 0`.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU, 10 MUL (low WIDTH bits of unsigned product), 11 MULHU (high WIDTH bits), 12 DIVU, 13 REMU, 14–15 reserved.
- ADD/SUB wrap modulo 2^WIDTH. Shifts use `b[SHW-1:0]` only; upper bits of `b` ignored. SRA replicates `a[WIDTH-1]`.
- Reserved opcodes: result 0, single-cycle path, no error flag.
- Operands and opcode captured into internal registers on acceptance (`in_valid && in_ready`); inputs may change afterwards.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready=1`. On acceptance, ops 0–9 and 14–15 → DONE with result registered; ops 10–13 → BUSY, counter loaded with WIDTH.
  - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide), counter decrements; at counter reaching 0 → DONE with result registered.
  - DONE: `out_valid=1`, `result`/`zero` held stable; on `out_ready` → IDLE.
- `in_ready` is 1 only in IDLE; no overlap of accept and deliver.
- DIVU by zero: quotient all ones; REMU by zero: remainder = `a`. Full WIDTH iterations still run.
- MUL/MULHU share one 2·WIDTH product register; DIVU/REMU share quotient/remainder registers.

## Timing
- Reset: state IDLE, `in_ready=1`, `out_valid=0`, `result=0`, `zero=1`, counter 0, datapath registers 0.
- Single-cycle ops: accepted at edge N → `out_valid=1` after edge N+1... i.e. visible in cycle N+1 (latency 1).
- Mul/div ops: `out_valid=1` in cycle N+WIDTH+1 (latency WIDTH+1; 33 at WIDTH=32).
- `out_valid` asserted with `out_ready` low: result holds indefinitely, no further acceptance.
- Earliest next acceptance: cycle after the out handshake (throughput 1 op / 2 cycles for single-cycle ops).
- `rst` asserted in any state (including mid-BUSY): next cycle matches reset values; in-flight operation discarded, no output produced.
- `in_valid` while not in IDLE: ignored, not buffered.

## Configuration
- `ALU_MULDIV_EN` defined: ops 10–13 implemented as above with BUSY state, counter and mul/div datapath.
- Not defined: no BUSY datapath synthesised; ops 10–13 treated as reserved (result 0, latency 1). BUSY state is unreachable; FSM and handshake otherwise unchanged.

## Test plan
- Reset then ADD a=0xFFFF_FFFF b=1 → `out_valid` one cycle after accept, `result=0`, `zero=1`; SUB a=0 b=1 → `0xFFFF_FFFF`, `zero=0`.
- SRA a=0x8000_0000 b=0x0000_0024 (shift 4) → `0xF800_0000`; SRL same → `0x0800_0000`; SLT a=0xFFFF_FFFF b=1 → 1, SLTU → 0.
- With `ALU_MULDIV_EN`: MULHU a=b=0xFFFF_FFFF → `0xFFFF_FFFE` at cycle accept+33; MUL → `0x0000_0001`; DIVU 100/7 → 14, REMU → 2.
- DIVU a=0x1234 b=0 → `0xFFFF_FFFF`; REMU → `0x1234`; latency still 33.
- Back-pressure: hold `out_ready=0` 10 cycles after result → `result` stable, `in_ready=0`, new `in_valid` ignored; release → IDLE next cycle, then accept.
- Assert `rst` in BUSY cycle 5 of a MUL → `out_valid` never rises for it, `in_ready=1` cycle after reset; without `ALU_MULDIV_EN` MUL 3×5 → 0 at latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with a registered result. The iterative unsigned
// mul/div unit (ops 10-13) is built only when ALU_MULDIV_EN is defined.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             w_accept;
    logic [WIDTH-1:0] w_alu;

    function automatic logic [WIDTH-1:0] f_alu(input logic [3:0] op_i,
                                               input logic [WIDTH-1:0] a_i,
                                               input logic [WIDTH-1:0] b_i);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHW-1:0]          sh;
        sa    = a_i;
        sb    = b_i;
        sh    = b_i[SHW-1:0];
        f_alu = '0;
        case (op_i)
            4'd0: f_alu = a_i + b_i;
            4'd1: f_alu = a_i - b_i;
            4'd2: f_alu = a_i & b_i;
            4'd3: f_alu = a_i | b_i;
            4'd4: f_alu = a_i ^ b_i;
            4'd5: f_alu = a_i << sh;
            4'd6: f_alu = a_i >> sh;
            4'd7: f_alu = sa >>> sh;
            4'd8: f_alu = {{(WIDTH-1){1'b0}}, (sa < sb)};
            4'd9: f_alu = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            default: f_alu = '0;
        endcase
    endfunction

    assign w_accept  = in_valid && r_in_ready;
    assign w_alu     = f_alu(op, a, b);
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;

`ifdef ALU_MULDIV_EN
    localparam int CNTW = $clog2(WIDTH + 1);

    logic [CNTW-1:0]    r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     w_psum;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_md_res;
    logic               w_ge;
    logic               w_is_md;

    // Both radix-2 engines step every BUSY cycle; r_op picks which one is reported.
    assign w_psum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opb} : '0);
    assign w_prod_nxt = {w_psum, r_prod[WIDTH-1:1]};
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_opb});
    assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_opb;
    assign w_rem_nxt  = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_ge};
    assign w_is_md    = (op >= 4'd10) && (op <= 4'd13);

    always_comb begin
        w_md_res = '0;
        case (r_op)
            4'd10:   w_md_res = w_prod_nxt[WIDTH-1:0];
            4'd11:   w_md_res = w_prod_nxt[2*WIDTH-1:WIDTH];
            4'd12:   w_md_res = w_quo_nxt;
            4'd13:   w_md_res = w_rem_nxt;
            default: w_md_res = '0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
`ifdef ALU_MULDIV_EN
            r_cnt       <= '0;
            r_op        <= '0;
            r_opb       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_prod      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
`ifdef ALU_MULDIV_EN
                        if (w_is_md) begin
                            r_state    <= S_BUSY;
                            r_in_ready <= 1'b0;
                            r_cnt      <= CNTW'(WIDTH);
                            r_op       <= op;
                            r_opb      <= b;
                            r_prod     <= {{WIDTH{1'b0}}, a};
                            r_quo      <= a;
                            r_rem      <= '0;
                        end else
`endif
                        begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu;
                            r_zero      <= (w_alu == '0);
                        end
                    end
                end
                S_BUSY: begin
`ifdef ALU_MULDIV_EN
                    r_prod <= w_prod_nxt;
                    r_quo  <= w_quo_nxt;
                    r_rem  <= w_rem_nxt;
                    r_cnt  <= r_cnt - CNTW'(1);
                    // The last step's next-state values are registered directly as the result.
                    if (r_cnt == CNTW'(1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_md_res;
                        r_zero      <= (w_md_res == '0);
                    end
`else
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues expected results at acceptance,
// an independent monitor pops and checks them (value, zero flag, latency, hold).
module tb_alu_seq;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   force_stall = 1'b0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the operation rules.
    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0]        p;
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        int unsigned        sh;
        sx = x;
        sy = y;
        sh = y % 32;
        p  = 64'(x) * 64'(y);
        case (o)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return x ^ y;
            4'd5:  return x << sh;
            4'd6:  return x >> sh;
            4'd7:  return sx >>> sh;
            4'd8:  return (sx < sy) ? 32'd1 : 32'd0;
            4'd9:  return (x < y) ? 32'd1 : 32'd0;
            4'd10: return MD ? p[31:0] : 32'd0;
            4'd11: return MD ? p[63:32] : 32'd0;
            4'd12: return MD ? ((y == 0) ? 32'hFFFF_FFFF : x / y) : 32'd0;
            4'd13: return MD ? ((y == 0) ? x : x % y) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] o);
        return (MD && o >= 4'd10 && o <= 4'd13) ? 33 : 1;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input bit stall);
        int t = 0;
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        force_stall = stall;
        sb_q.push_back('{res: e, lat: model_lat(o), acc: cyc});
        @(negedge clk);
        in_valid = 1'b0;
        op = 4'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic run_dir(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] e_md, input logic [31:0] e_nomd, input bit stall);
        issue(o, x, y, MD ? e_md : e_nomd, stall);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb_q.size() != 0 || out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: checks each result on its first valid cycle, then its stability while stalled.
    initial begin
        bit          seen;
        bit          idle_chk;
        int          w;
        logic [31:0] held;
        exp_t        e;
        seen = 1'b0; idle_chk = 1'b0; w = 0; held = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
                idle_chk = 1'b0;
                out_ready = 1'b1;
            end else if (idle_chk) begin
                check("idle_after_handshake", {62'd0, out_valid, in_ready}, 64'd1);
                idle_chk = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    held = result;
                    if (sb_q.size() == 0) begin
                        check("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", 64'(result), 64'(e.res));
                        check("zero_flag", 64'(zero), 64'(e.res == 0));
                        check("latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                    w = force_stall ? 10 : int'($urandom_range(0, 3));
                    force_stall = 1'b0;
                end else begin
                    check("result_stable", 64'(result), 64'(held));
                    check("in_ready_low_in_done", 64'(in_ready), 64'd0);
                    if (w > 0) w--;
                end
                out_ready = (w == 0);
                if (out_ready) begin
                    seen = 1'b0;
                    idle_chk = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [3:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        bit          bad;
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_zero", 64'(zero), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        run_dir(4'd0,  32'hFFFF_FFFF, 32'd1,         32'h0,         32'h0,         1'b0);
        run_dir(4'd1,  32'd0,         32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_dir(4'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 32'hF800_0000, 1'b0);
        run_dir(4'd6,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 32'h0800_0000, 1'b0);
        run_dir(4'd8,  32'hFFFF_FFFF, 32'd1,         32'd1,         32'd1,         1'b0);
        run_dir(4'd9,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,         1'b0);
        run_dir(4'd5,  32'd1,         32'h0000_0021, 32'd2,         32'd2,         1'b0);
        run_dir(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0,         1'b0);
        run_dir(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         1'b0);
        run_dir(4'd12, 32'd100,       32'd7,         32'd14,        32'h0,         1'b0);
        run_dir(4'd13, 32'd100,       32'd7,         32'd2,         32'h0,         1'b0);
        run_dir(4'd12, 32'h1234,      32'd0,         32'hFFFF_FFFF, 32'h0,         1'b0);
        run_dir(4'd13, 32'h1234,      32'd0,         32'h1234,      32'h0,         1'b0);
        run_dir(4'd10, 32'd3,         32'd5,         32'd15,        32'h0,         1'b0);
        run_dir(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         32'h0,         1'b0);
        run_dir(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0);
        run_dir(4'd2,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'h0000_F000, 1'b1);
        run_dir(4'd3,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 32'h0F0F_00F0, 1'b0);
        run_dir(4'd4,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 32'h00FF_FF00, 1'b0);

        for (int i = 0; i < 80; i++) begin
            ro = 4'($urandom_range(0, 15));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 7) == 0) ry = 32'd0;
            else if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 40));
            issue(ro, rx, ry, model(ro, rx, ry), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        if (MD) begin
            check("pre_busy_in_ready", 64'(in_ready), 64'd1);
            op = 4'd10; a = 32'd3; b = 32'd5; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (4) @(negedge clk);
            check("busy_in_ready_low", 64'(in_ready), 64'd0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_busy_in_ready", 64'(in_ready), 64'd1);
            check("rst_busy_out_valid", 64'(out_valid), 64'd0);
            check("rst_busy_result", 64'(result), 64'd0);
            check("rst_busy_zero", 64'(zero), 64'd1);
            bad = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (out_valid) bad = 1'b1;
            end
            check("no_output_after_rst", 64'(bad), 64'd0);
            issue(4'd0, 32'd2, 32'd3, 32'd5, 1'b0);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
